// File: rtl/apb_rr_master_arbiter.sv
// Round-robin share of one APB master port among NoReqs requesters; grant registers the payload (psel after 1 edge, penable after 2).
// Requests wait while a transfer is in flight; ACCESS stretches with pready_i and a completion pulse returns to the owner.
module apb_rr_master_arbiter #(
   parameter  int NoReqs    = 4,
   parameter  int AddrWidth = 32,
   parameter  int DataWidth = 32,
   localparam int StrbWidth = (DataWidth + 7) / 8,
   localparam int IdxWidth  = (NoReqs > 1) ? $clog2(NoReqs) : 1
) (
   input  logic                          pclk_i,
   input  logic                          preset_i,
   input  logic [NoReqs-1:0]             req_valid_i,
   input  logic [NoReqs-1:0]             req_write_i,
   input  logic [NoReqs*AddrWidth-1:0]   req_addr_i,
   input  logic [NoReqs*DataWidth-1:0]   req_wdata_i,
   input  logic [NoReqs*StrbWidth-1:0]   req_strb_i,
   output logic [NoReqs-1:0]             rsp_valid_o,
   output logic [DataWidth-1:0]          rsp_rdata_o,
   output logic                          rsp_slverr_o,
   output logic [IdxWidth-1:0]           gnt_idx_o,
   output logic                          busy_o,
   output logic                          psel_o,
   output logic                          penable_o,
   output logic                          pwrite_o,
   output logic [AddrWidth-1:0]          paddr_o,
   output logic [DataWidth-1:0]          pwdata_o,
   output logic [StrbWidth-1:0]          pstrb_o,
   input  logic [DataWidth-1:0]          prdata_i,
   input  logic                          pready_i,
   input  logic                          pslverr_i
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t               state_q, state_d;
   logic [IdxWidth-1:0]  last_q, last_d;
   logic [IdxWidth-1:0]  gnt_d;
   logic                 psel_d, penable_d, pwrite_d;
   logic [AddrWidth-1:0] paddr_d;
   logic [DataWidth-1:0] pwdata_d;
   logic [StrbWidth-1:0] pstrb_d;

   logic                 found;
   logic [IdxWidth-1:0]  pick;
   logic [IdxWidth-1:0]  cand;

   logic [AddrWidth-1:0] addr_arr  [NoReqs];
   logic [DataWidth-1:0] wdata_arr [NoReqs];
   logic [StrbWidth-1:0] strb_arr  [NoReqs];

   for (genvar i = 0; i < NoReqs; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr_i[i*AddrWidth +: AddrWidth];
      assign wdata_arr[i] = req_wdata_i[i*DataWidth +: DataWidth];
      assign strb_arr[i]  = req_strb_i[i*StrbWidth +: StrbWidth];
   end

   // Search starts just after the last grant, so the last winner has lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= NoReqs; k++) begin
         cand = IdxWidth'((int'(last_q) + k) % NoReqs);
         if (!found && req_valid_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_idx_o;
      psel_d    = psel_o;
      penable_d = penable_o;
      pwrite_d  = pwrite_o;
      paddr_d   = paddr_o;
      pwdata_d  = pwdata_o;
      pstrb_d   = pstrb_o;
      case (state_q)
         IDLE: begin
            if (found) begin
               pwrite_d  = req_write_i[pick];
               paddr_d   = addr_arr[pick];
               pwdata_d  = wdata_arr[pick];
               pstrb_d   = strb_arr[pick];
               psel_d    = 1'b1;
               penable_d = 1'b0;
               last_d    = pick;
               gnt_d     = pick;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (pready_i) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state_q   <= IDLE;
         last_q    <= IdxWidth'(NoReqs - 1);
         gnt_idx_o <= '0;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
         pwrite_o  <= 1'b0;
         paddr_o   <= '0;
         pwdata_o  <= '0;
         pstrb_o   <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_idx_o <= gnt_d;
         psel_o    <= psel_d;
         penable_o <= penable_d;
         pwrite_o  <= pwrite_d;
         paddr_o   <= paddr_d;
         pwdata_o  <= pwdata_d;
         pstrb_o   <= pstrb_d;
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign rsp_rdata_o  = prdata_i;
   assign rsp_slverr_o = pslverr_i;

   // A reset landing on the completing cycle swallows the response; the owner reissues.
   always_comb begin
      rsp_valid_o = '0;
      if (state_q == ACCESS && pready_i && !preset_i)
         rsp_valid_o[gnt_idx_o] = 1'b1;
   end

   a_req_held: assert property (@(posedge pclk_i) disable iff (preset_i)
      (state_q != IDLE) |-> req_valid_i[gnt_idx_o]);

   a_setup_access: assert property (@(posedge pclk_i) disable iff (preset_i)
      (state_q == SETUP) |=> (state_q == ACCESS));

endmodule
